// File: rtl/regfile_pkg.sv
// Shared register-file defaults (data width, register count, requester count, address width).
package regfile_pkg;

  localparam int RF_NREQ = 4;
  localparam int RF_NREG = 32;
  localparam int RF_DW   = 32;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int rf_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int RF_AW = rf_bits(RF_NREG);

endpackage

// File: rtl/regfile_rr_pick.sv
// Combinational winner pick: first set request at or after i_ptr, wrapping to 0.
module regfile_rr_pick
  import regfile_pkg::*;
#(
  parameter int NREQ = RF_NREQ,
  parameter int IW   = rf_bits(RF_NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic            o_vld,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx
);

  int w_j;

  always_comb begin
    o_vld    = 1'b0;
    o_onehot = '0;
    o_idx    = '0;
    w_j      = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (!o_vld && i_req[w_j]) begin
        o_vld         = 1'b1;
        o_onehot[w_j] = 1'b1;
        o_idx         = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// Write arbiter for a shared register file: one registered grant/write-enable pulse per cycle.
// Define REGFILE_WR_ARB_RR_EN for round-robin; otherwise fixed priority (lowest index wins).
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter  int NREQ = RF_NREQ,
  parameter  int NREG = RF_NREG,
  parameter  int DW   = RF_DW,
  localparam int AW   = rf_bits(NREG),
  localparam int IW   = rf_bits(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREG-1:0]    wen,
  output logic [DW-1:0]      wdata_out,
  output logic               err
);

  logic [NREQ-1:0] r_gnt;
  logic [NREG-1:0] r_wen;
  logic [DW-1:0]   r_wdata;
  logic            r_err;

  logic [NREQ-1:0] w_elig;
  logic [IW-1:0]   w_ptr;
  logic            w_vld;
  logic [NREQ-1:0] w_onehot;
  logic [IW-1:0]   w_idx;
  logic [AW-1:0]   w_addr_sel;
  logic [DW-1:0]   w_wdata_sel;
  logic            w_in_range;
  logic [NREG-1:0] w_wen_dec;

  // A requester granted last cycle sits out this cycle, which bounds a held request to every other cycle.
  assign w_elig = req & ~r_gnt;

`ifdef REGFILE_WR_ARB_RR_EN
  logic [IW-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_vld) begin
      r_ptr <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  regfile_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req    (w_elig),
    .i_ptr    (w_ptr),
    .o_vld    (w_vld),
    .o_onehot (w_onehot),
    .o_idx    (w_idx)
  );

  assign w_addr_sel  = addr[int'(w_idx)*AW +: AW];
  assign w_wdata_sel = wdata[int'(w_idx)*DW +: DW];
  assign w_in_range  = {1'b0, w_addr_sel} < (AW+1)'(NREG);

  always_comb begin
    w_wen_dec = '0;
    for (int r = 0; r < NREG; r++) begin
      if (w_vld && w_in_range && (w_addr_sel == AW'(r))) w_wen_dec[r] = 1'b1;
    end
  end

  // Out-of-range winners still get their grant so they can move on; only the write is suppressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt   <= '0;
      r_wen   <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_gnt <= w_onehot;
      r_wen <= w_wen_dec;
      r_err <= w_vld & ~w_in_range;
      if (w_vld) r_wdata <= w_wdata_sel;
    end
  end

  assign gnt       = r_gnt;
  assign wen       = r_wen;
  assign wdata_out = r_wdata;
  assign err       = r_err;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Scoreboard bench for regfile_wr_arb with NREG=20 so out-of-range addresses are reachable.
module tb_regfile_wr_arb;

  localparam int NREQ = 4;
  localparam int NREG = 20;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREG-1:0]    wen;
  logic [DW-1:0]      wdata_out;
  logic               err;

  regfile_wr_arb #(
    .NREQ (NREQ),
    .NREG (NREG),
    .DW   (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .wen       (wen),
    .wdata_out (wdata_out),
    .err       (err)
  );

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [NREG-1:0] wen;
    logic [DW-1:0]   wd;
    logic            err;
    string           name;
  } exp_t;

  exp_t        q[$];
  int          n_cmp;
  int          n_fail;
  logic [DW-1:0] shadow [NREG];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic push(input string nm, input logic [NREQ-1:0] g, input int widx,
                      input logic [DW-1:0] d, input logic e);
    exp_t x;
    x.gnt  = g;
    x.wen  = '0;
    if (widx >= 0) x.wen[widx] = 1'b1;
    x.wd   = d;
    x.err  = e;
    x.name = nm;
    q.push_back(x);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [63:0] outs();
    return {7'b0, gnt, wen, wdata_out, err};
  endfunction

  initial begin
    exp_t x;
    n_cmp  = 0;
    n_fail = 0;
    for (int r = 0; r < NREG; r++) shadow[r] = '0;
    rst   = 1'b1;
    req   = '0;
    addr  = '0;
    wdata = '0;

    // Monitor: any output pulse is matched against the next expected transaction.
    fork
      forever begin
        @(negedge clk);
        if (!rst && (gnt != '0 || wen != '0 || err)) begin
          if (q.size() == 0) begin
            check("unexpected_pulse", outs(), 64'd0);
          end else begin
            x = q.pop_front();
            check(x.name, outs(), {7'b0, x.gnt, x.wen, x.wd, x.err});
          end
          for (int r = 0; r < NREG; r++) if (wen[r]) shadow[r] = wdata_out;
        end
      end
    join_none

    // Reset with all requesters pending, then release: held requests.
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), 32'hA000_0000 + i);
    tick(3);
    check("reset_outputs", outs(), 64'd0);
`ifdef REGFILE_WR_ARB_RR_EN
    push("held_g0", 4'b0001, 1, 32'hA000_0000, 1'b0);
    push("held_g1", 4'b0010, 2, 32'hA000_0001, 1'b0);
    push("held_g2", 4'b0100, 3, 32'hA000_0002, 1'b0);
    push("held_g3", 4'b1000, 4, 32'hA000_0003, 1'b0);
    push("held_g4", 4'b0001, 1, 32'hA000_0000, 1'b0);
`else
    push("held_g0", 4'b0001, 1, 32'hA000_0000, 1'b0);
    push("held_g1", 4'b0010, 2, 32'hA000_0001, 1'b0);
    push("held_g2", 4'b0001, 1, 32'hA000_0000, 1'b0);
    push("held_g3", 4'b0010, 2, 32'hA000_0001, 1'b0);
    push("held_g4", 4'b0001, 1, 32'hA000_0000, 1'b0);
`endif
    rst = 1'b0;
    tick(5);
    req = '0;
    tick(3);

    // Single write, dropped the cycle after its grant.
    push("single", 4'b0001, 5, 32'haaaaaaaa, 1'b0);
    set_req(0, 5'd5, 32'haaaaaaaa);
    req = 4'b0001;
    tick(1);
    req = '0;
    tick(3);
    check("single_reg5", {32'b0, shadow[5]}, 64'h0000_0000_aaaa_aaaa);

    // Two requesters on the same address: both write, later grant lands last.
    push("collide_r1", 4'b0010, 3, 32'h55555555, 1'b0);
    push("collide_r2", 4'b0100, 3, 32'hffffffff, 1'b0);
    set_req(1, 5'd3, 32'h55555555);
    set_req(2, 5'd3, 32'hffffffff);
    req = 4'b0110;
    tick(1);
    req = 4'b0100;
    tick(1);
    req = '0;
    tick(3);
    check("collide_reg3", {32'b0, shadow[3]}, 64'h0000_0000_ffff_ffff);

    // Out-of-range address: grant and error, no write enable.
    push("out_of_range", 4'b1000, -1, 32'h12345678, 1'b1);
    set_req(3, 5'd25, 32'h12345678);
    req = 4'b1000;
    tick(1);
    req = '0;
    tick(3);

    // Reset asserted between edges while a grant pulse is live.
    set_req(0, 5'd7, 32'hdeadbeef);
    req = 4'b0001;
    tick(1);
    check("pulse_live", {60'b0, gnt}, 64'h1);
    #1 rst = 1'b1;
    #1 check("async_abort", outs(), 64'd0);
    set_req(0, 5'd8, 32'h11111111);
    set_req(1, 5'd9, 32'h22222222);
    req = 4'b0011;
    push("post_rst_g0", 4'b0001, 8, 32'h11111111, 1'b0);
    push("post_rst_g1", 4'b0010, 9, 32'h22222222, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(1);
    req = 4'b0010;
    tick(1);
    req = '0;
    tick(3);
    check("aborted_reg7", {32'b0, shadow[7]}, 64'd0);
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
